softmax_stream: RTL and testbench
=================================

SOFTMAX_STREAM -- requirements
Module: softmax_stream

Interface
REQ-001 The module SHALL take parameter N, default 8, as the number of 16-bit lanes per beat.
REQ-002 The module SHALL take parameter DEPTH, default 16, as the maximum number of beats per vector; SW = 16 + clog2(N*DEPTH).
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  clock enable; when low, all registers SHALL hold and no handshake SHALL complete.
REQ-006 in_valid  input  1; in_ready  output  1  input beat handshake.
REQ-007 in_x_flat  input  N*16  lane i at [i*16 +: 16], signed Q8.8.
REQ-008 in_keep  input  N  lane mask; in_last  input  1  final beat of vector.
REQ-009 out_valid  output  1; out_ready  input  1  output beat handshake.
REQ-010 prob_flat  output  N*16  lane i unsigned Q1.15 probability; out_keep  output  N; out_last  output  1.
REQ-011 busy  output  1  high when state is not LOAD; overflow  output  1  sticky error flag.

Function
REQ-012 States SHALL be LOAD, SUM, LOG, OUT; transfer SHALL occur only on cycles with en=1.
REQ-013 LOAD: in_ready=1; accepted beat (in_valid&in_ready) SHALL be written with its keep into buffer entry B, B incremented; kept lanes SHALL update running max M (signed compare).
REQ-014 M SHALL be initialised to 16'h8000 and B to 0 on entry to LOAD.
REQ-015 Accepting a beat with in_last=1, or the DEPTH-th beat, SHALL move to SUM; DEPTH-th beat without in_last SHALL set overflow.
REQ-016 exp2neg(d), d unsigned 16-bit Q8.8: k=d[15:8], f=d[7:0]; result = (32768 - f*64) >> k, 0 if k>=16.
REQ-017 SUM: one buffer entry per cycle, beats 0..B-1; S (SW bits, cleared on entering SUM) SHALL accumulate exp2neg(M - x) over kept lanes; M - x is non-negative, saturated to 16'hFFFF.
REQ-018 LOG: one cycle; p = leading-one index of S, Lf = 8 bits immediately below the leading one (zero-padded); L = {p-15, Lf} Q8.8; if S < 32768, L=0.
REQ-019 OUT: out_valid=1, beat index R from 0; lane i prob = exp2neg(sat16((M - x_i) + L)) if keep_i, else 0; out_keep = stored keep; out_last = (R == B-1).
REQ-020 out_valid&out_ready SHALL advance R; while out_ready=0 all outputs SHALL hold stable.
REQ-021 Handshake of beat B-1 SHALL return to LOAD; in_ready SHALL be 1 the following cycle.
REQ-022 First out_valid SHALL occur exactly B+1 enabled rising edges after the edge accepting the last beat.
REQ-023 in_ready SHALL be 0 in SUM, LOG, OUT; in_valid there SHALL be ignored.
REQ-024 Vector with all lanes masked SHALL produce all-zero prob_flat with stored keep, with normal timing.
REQ-025 overflow SHALL clear only on rst.

Reset
REQ-026 rst=1 SHALL asynchronously force LOAD, B=0, R=0, M=16'h8000, S=0, overflow=0, out_valid=0, out_last=0, prob_flat=0, out_keep=0, busy=0, in_ready=1 after release.
REQ-027 rst during any state SHALL abandon the vector; no further output beat SHALL appear for it.

Verification
REQ-028 N=8, one beat, all x=16'h0100, keep=8'hFF, last=1 -> S=262144, L=16'h0300, every lane 16'd4096, out_last=1, out_valid after 2 edges.
REQ-029 One beat, lane0=16'h0200, keep=8'h01 -> lane0 16'h8000, lanes1..7 0, out_keep=8'h01.
REQ-030 One beat, lane0=16'h0100, lane1=16'h0000, keep=8'h03 -> S=49152, L=16'h0080, lane0 24576, lane1 12288.
REQ-031 Three beats, out_ready low 5 cycles in OUT -> prob_flat/out_last stable, 3 output beats, last on third, out_valid after 4 edges.
REQ-032 DEPTH beats, in_last never set -> overflow=1, DEPTH output beats, out_last on last; overflow persists into next vector.
REQ-033 rst pulse mid-OUT -> out_valid=0 immediately, in_ready=1, next vector processed correctly.

Source files
------------

// File: rtl/softmax_stream.sv
// Streaming softmax over masked vectors of up to DEPTH beats of N Q8.8 lanes.
// Base-2 softmax: buffer and track max, sum 2^-(M-x), take log2 of the sum, emit 2^-(M-x+L).

module softmax_stream_lane (
  input  logic [15:0] x,
  input  logic [15:0] m,
  input  logic [15:0] l,
  input  logic        keep,
  output logic [15:0] term,
  output logic [15:0] prob
);
  function automatic logic [15:0] exp2neg(input logic [15:0] d);
    logic [15:0] base;
    base = 16'd32768 - {2'b00, d[7:0], 6'd0};
    return (d[15:8] >= 8'd16) ? 16'd0 : (base >> d[15:8]);
  endfunction

  logic signed [17:0] diff;
  logic        [15:0] dsat;
  logic        [16:0] dl;
  logic        [15:0] dl_sat;

  always_comb begin
    diff   = $signed({{2{m[15]}}, m}) - $signed({{2{x[15]}}, x});
    dsat   = diff[17] ? 16'd0 : (diff[16] ? 16'hFFFF : diff[15:0]);
    dl     = {1'b0, dsat} + {1'b0, l};
    dl_sat = dl[16] ? 16'hFFFF : dl[15:0];
    term   = keep ? exp2neg(dsat)   : 16'd0;
    prob   = keep ? exp2neg(dl_sat) : 16'd0;
  end
endmodule

module softmax_stream #(
  parameter int N     = 8,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*16-1:0]   in_x_flat,
  input  logic [N-1:0]      in_keep,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*16-1:0]   prob_flat,
  output logic [N-1:0]      out_keep,
  output logic              out_last,
  output logic              busy,
  output logic              overflow
);
  localparam int SW = 16 + $clog2(N*DEPTH);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {LOAD, SUM, LOG, OUT} state_t;

  state_t         state, state_nx;
  logic [BW-1:0]  b_cnt, r_idx;
  logic [15:0]    m_max, l_log;
  logic [SW-1:0]  s_acc;

  logic [N*16-1:0] buf_x [DEPTH];
  logic [N-1:0]    buf_k [DEPTH];

  logic [N*16-1:0]     row_x;
  logic [N-1:0]        row_k;
  logic [N-1:0][15:0]  terms, probs;
  logic [SW-1:0]       term_sum;
  logic [15:0]         mx, l_nx;
  logic [7:0]          lf;
  logic                in_acc, out_acc, last_row, beat_end;

  assign row_x    = buf_x[r_idx[IW-1:0]];
  assign row_k    = buf_k[r_idx[IW-1:0]];
  assign in_acc   = en && (state == LOAD) && in_valid;
  assign out_acc  = en && (state == OUT) && out_ready;
  assign last_row = (r_idx == b_cnt - 1'b1);
  assign beat_end = in_acc && (in_last || (b_cnt == BW'(DEPTH - 1)));

  // The same lane hardware serves SUM (term) and OUT (prob) since both walk row r_idx.
  for (genvar i = 0; i < N; i++) begin : g_lane
    softmax_stream_lane u_lane (
      .x    (row_x[i*16 +: 16]),
      .m    (m_max),
      .l    (l_log),
      .keep (row_k[i]),
      .term (terms[i]),
      .prob (probs[i])
    );
  end

  always_comb begin
    term_sum = '0;
    for (int i = 0; i < N; i++) term_sum = term_sum + SW'(terms[i]);
  end

  always_comb begin
    mx = m_max;
    for (int i = 0; i < N; i++)
      if (in_keep[i] && ($signed(in_x_flat[i*16 +: 16]) > $signed(mx))) mx = in_x_flat[i*16 +: 16];
  end

  // log2 of the sum: integer part from the leading one, 8 fraction bits taken below it
  always_comb begin
    int p;
    p  = 0;
    lf = '0;
    for (int i = 0; i < SW; i++) if (s_acc[i]) p = i;
    for (int j = 0; j < 8; j++) if (p - 1 - j >= 0) lf[7-j] = s_acc[p-1-j];
    l_nx = (s_acc[SW-1:15] == '0) ? 16'd0 : {8'(p - 15), lf};
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= LOAD;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      LOAD: if (beat_end)           state_nx = SUM;
      SUM:  if (en && last_row)     state_nx = LOG;
      LOG:  if (en)                 state_nx = OUT;
      OUT:  if (out_acc && last_row) state_nx = LOAD;
      default:                      state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_cnt    <= '0;
      r_idx    <= '0;
      m_max    <= 16'h8000;
      s_acc    <= '0;
      l_log    <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      case (state)
        LOAD: if (in_valid) begin
          b_cnt <= b_cnt + 1'b1;
          m_max <= mx;
          if ((b_cnt == BW'(DEPTH - 1)) && !in_last) overflow <= 1'b1;
          if (beat_end) begin
            s_acc <= '0;
            r_idx <= '0;
          end
        end
        SUM: begin
          s_acc <= s_acc + term_sum;
          r_idx <= last_row ? '0 : r_idx + 1'b1;
        end
        LOG: begin
          l_log <= l_nx;
          r_idx <= '0;
        end
        OUT: if (out_ready) begin
          if (last_row) begin
            r_idx <= '0;
            b_cnt <= '0;
            m_max <= 16'h8000;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Beat storage carries no reset; entries are always written before being read.
  always_ff @(posedge clk)
    if (in_acc) begin
      buf_x[b_cnt[IW-1:0]] <= in_x_flat;
      buf_k[b_cnt[IW-1:0]] <= in_keep;
    end

  assign in_ready  = (state == LOAD);
  assign busy      = (state != LOAD);
  assign out_valid = (state == OUT);
  assign out_last  = (state == OUT) && last_row;
  assign out_keep  = (state == OUT) ? row_k : '0;
  assign prob_flat = (state == OUT) ? probs : '0;
endmodule

// File: tb/tb_softmax_stream.sv
// Randomized bench for softmax_stream against an arithmetic base-2 softmax model.

module tb_softmax_stream;
  localparam int N = 8, DEPTH = 16;

  logic clk = 1'b0, rst, en, in_valid, in_ready, in_last;
  logic out_valid, out_ready, out_last, busy, overflow;
  logic [N*16-1:0] in_x_flat, prob_flat;
  logic [N-1:0]    in_keep, out_keep;

  softmax_stream #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_x_flat(in_x_flat), .in_keep(in_keep), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .prob_flat(prob_flat),
    .out_keep(out_keep), .out_last(out_last), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [15:0]     vx  [DEPTH][N];
  logic [N-1:0]    vk  [DEPTH];
  logic [N*16-1:0] epk [DEPTH];
  logic [N*16-1:0] gp  [DEPTH];
  logic [N-1:0]    gk  [DEPTH];
  logic            gl  [DEPTH];
  int ngot, lat, unstable;

  function automatic int exp2neg(int d);
    int k, f;
    k = d >> 8;
    f = d & 255;
    if (k >= 16) return 0;
    return (32768 - f * 64) >> k;
  endfunction

  // softmax in base 2: p_i = 2^-(M - x_i) / S, with S replaced by 2^L from a piecewise-linear log2
  task automatic model(input int nb);
    int m, xi, p, l, d;
    longint s;
    m = -32768;
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < N; i++) begin
        xi = int'($signed(vx[b][i]));
        if (vk[b][i] && xi > m) m = xi;
      end
    s = 0;
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < N; i++)
        if (vk[b][i]) s += exp2neg(m - int'($signed(vx[b][i])));
    l = 0;
    if (s >= 32768) begin
      p = 0;
      while ((s >> (p + 1)) != 0) p++;
      l = (p - 15) * 256 + int'((s >> (p - 8)) & 255);
    end
    for (int b = 0; b < nb; b++) begin
      epk[b] = '0;
      for (int i = 0; i < N; i++)
        if (vk[b][i]) begin
          d = m - int'($signed(vx[b][i])) + l;
          if (d > 65535) d = 65535;
          epk[b][i*16 +: 16] = 16'(exp2neg(d));
        end
    end
  endtask

  task automatic gen_vec(input int nb, input int kmode);
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < N; i++)
        vx[b][i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
      vk[b] = (kmode == 1) ? '1 : (kmode == 2) ? '0 : N'($urandom);
    end
  endtask

  task automatic send(input int nb, input bit with_last);
    bit acc;
    int w;
    for (int b = 0; b < nb; b++) begin
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) in_x_flat[i*16 +: 16] = vx[b][i];
      in_keep = vk[b];
      in_last = with_last && (b == nb - 1);
      w = 0;
      do begin
        @(negedge clk); acc = in_ready && en;
        @(posedge clk); #1; w++;
      end while (!acc && w < 50);
      if (!acc) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Latency counts enabled edges from the last accepting edge to the first out_valid.
  task automatic collect(input int stall_pct, input int hold0);
    bit done, rdy, pstall, pl;
    logic [N*16-1:0] pp;
    logic [N-1:0] pk;
    int cyc;
    lat = 0; ngot = 0; unstable = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (lat > 200) return;
      @(posedge clk); lat++;
    end
    done = 0; cyc = 0; pstall = 0; pp = '0; pk = '0; pl = 0;
    while (!done) begin
      if (out_valid) begin
        if (pstall && (prob_flat !== pp || out_keep !== pk || out_last !== pl)) unstable++;
        rdy = (cyc >= hold0) && ($urandom_range(0, 99) >= stall_pct);
        out_ready = rdy;
        if (rdy) begin
          gp[ngot] = prob_flat; gk[ngot] = out_keep; gl[ngot] = out_last;
          ngot++;
          done = out_last || (ngot >= DEPTH);
        end
        pp = prob_flat; pk = out_keep; pl = out_last; pstall = !rdy;
      end else done = 1;
      @(posedge clk); #1; out_ready = 1'b0; cyc++;
      if (cyc > 500) done = 1;
      if (!done) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_x_flat = '0; in_keep = '0;
    #12;
    n_cmp += 7;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    if (out_last  !== 1'b0) begin n_bad++; $display("FAIL reset out_last got %b want 0", out_last); end
    if (busy      !== 1'b0) begin n_bad++; $display("FAIL reset busy got %b want 0", busy); end
    if (overflow  !== 1'b0) begin n_bad++; $display("FAIL reset overflow got %b want 0", overflow); end
    if (prob_flat !== '0)   begin n_bad++; $display("FAIL reset prob_flat got %h want 0", prob_flat); end
    if (out_keep  !== '0)   begin n_bad++; $display("FAIL reset out_keep got %h want 0", out_keep); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    int e0 [4] = '{4096, 32768, 24576, 0};
    int e1 [4] = '{4096, 0, 12288, 0};
    for (int c = 0; c < 4; c++) begin
      gen_vec(1, 0);
      case (c)
        0: begin for (int i = 0; i < N; i++) vx[0][i] = 16'h0100; vk[0] = '1; end
        1: begin vx[0][0] = 16'h0200; vk[0] = 8'h01; end
        2: begin vx[0][0] = 16'h0100; vx[0][1] = 16'h0000; vk[0] = 8'h03; end
        default: vk[0] = '0;
      endcase
      model(1);
      send(1, 1'b1);
      collect(0, 0);
      n_cmp += 8;
      if (ngot !== 1) begin n_bad++; $display("FAIL dir%0d beats got %0d want 1", c, ngot); end
      if (lat !== 2)  begin n_bad++; $display("FAIL dir%0d latency got %0d want 2", c, lat); end
      if (gp[0] !== epk[0]) begin n_bad++; $display("FAIL dir%0d prob got %h want %h", c, gp[0], epk[0]); end
      if (int'(gp[0][15:0]) !== e0[c])  begin n_bad++; $display("FAIL dir%0d lane0 got %0d want %0d", c, gp[0][15:0], e0[c]); end
      if (int'(gp[0][31:16]) !== e1[c]) begin n_bad++; $display("FAIL dir%0d lane1 got %0d want %0d", c, gp[0][31:16], e1[c]); end
      if (gk[0] !== vk[0]) begin n_bad++; $display("FAIL dir%0d keep got %h want %h", c, gk[0], vk[0]); end
      if (gl[0] !== 1'b1)  begin n_bad++; $display("FAIL dir%0d last got %b want 1", c, gl[0]); end
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL dir%0d in_ready after got %b want 1", c, in_ready); end
    end
  endtask

  task automatic test_random();
    int nb;
    for (int v = 0; v < 8; v++) begin
      nb = $urandom_range(1, DEPTH - 1);
      gen_vec(nb, (v == 3) ? 1 : (v == 5) ? 2 : 0);
      model(nb);
      send(nb, 1'b1);
      collect(30, 0);
      n_cmp += 3;
      if (ngot !== nb)    begin n_bad++; $display("FAIL rnd%0d beats got %0d want %0d", v, ngot, nb); end
      if (lat !== nb + 1) begin n_bad++; $display("FAIL rnd%0d latency got %0d want %0d", v, lat, nb + 1); end
      if (unstable !== 0) begin n_bad++; $display("FAIL rnd%0d stall stability got %0d want 0", v, unstable); end
      for (int b = 0; b < nb && b < ngot; b++) begin
        n_cmp += 3;
        if (gp[b] !== epk[b]) begin n_bad++; $display("FAIL rnd%0d prob beat %0d got %h want %h", v, b, gp[b], epk[b]); end
        if (gk[b] !== vk[b])  begin n_bad++; $display("FAIL rnd%0d keep beat %0d got %h want %h", v, b, gk[b], vk[b]); end
        if (gl[b] !== (b == nb - 1)) begin n_bad++; $display("FAIL rnd%0d last beat %0d got %b", v, b, gl[b]); end
      end
    end
  endtask

  task automatic test_backpressure();
    gen_vec(3, 0);
    model(3);
    send(3, 1'b1);
    collect(0, 5);
    n_cmp += 3;
    if (ngot !== 3)     begin n_bad++; $display("FAIL bp beats got %0d want 3", ngot); end
    if (lat !== 4)      begin n_bad++; $display("FAIL bp latency got %0d want 4", lat); end
    if (unstable !== 0) begin n_bad++; $display("FAIL bp stability got %0d want 0", unstable); end
    for (int b = 0; b < 3 && b < ngot; b++) begin
      n_cmp += 2;
      if (gp[b] !== epk[b]) begin n_bad++; $display("FAIL bp prob beat %0d got %h want %h", b, gp[b], epk[b]); end
      if (gl[b] !== (b == 2)) begin n_bad++; $display("FAIL bp last beat %0d got %b", b, gl[b]); end
    end
  endtask

  task automatic test_enable();
    gen_vec(1, 1);
    en = 1'b0; in_valid = 1'b1; in_last = 1'b1; in_keep = '1; in_x_flat = '1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL en_hold busy got %b want 0", busy); end
    in_valid = 1'b0; in_last = 1'b0; en = 1'b1;
    model(2 - 1);
    send(1, 1'b1);
    collect(0, 0);
    n_cmp += 2;
    if (ngot !== 1) begin n_bad++; $display("FAIL en_hold beats got %0d want 1", ngot); end
    if (gp[0] !== epk[0]) begin n_bad++; $display("FAIL en_hold prob got %h want %h", gp[0], epk[0]); end
  endtask

  task automatic test_overflow();
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf before got %b want 0", overflow); end
    gen_vec(DEPTH, 0);
    model(DEPTH);
    send(DEPTH, 1'b0);
    collect(20, 0);
    n_cmp += 3;
    if (overflow !== 1'b1)  begin n_bad++; $display("FAIL ovf flag got %b want 1", overflow); end
    if (ngot !== DEPTH)     begin n_bad++; $display("FAIL ovf beats got %0d want %0d", ngot, DEPTH); end
    if (lat !== DEPTH + 1)  begin n_bad++; $display("FAIL ovf latency got %0d want %0d", lat, DEPTH + 1); end
    for (int b = 0; b < DEPTH && b < ngot; b++) begin
      n_cmp += 2;
      if (gp[b] !== epk[b]) begin n_bad++; $display("FAIL ovf prob beat %0d got %h want %h", b, gp[b], epk[b]); end
      if (gl[b] !== (b == DEPTH - 1)) begin n_bad++; $display("FAIL ovf last beat %0d got %b", b, gl[b]); end
    end
    gen_vec(2, 0);
    model(2);
    send(2, 1'b1);
    collect(0, 0);
    n_cmp += 3;
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf sticky got %b want 1", overflow); end
    if (ngot !== 2) begin n_bad++; $display("FAIL ovf next beats got %0d want 2", ngot); end
    if (gp[1] !== epk[1]) begin n_bad++; $display("FAIL ovf next prob got %h want %h", gp[1], epk[1]); end
  endtask

  task automatic test_rst_mid_out();
    int w, seen;
    gen_vec(3, 0);
    send(3, 1'b1);
    w = 0;
    do begin @(negedge clk); w++; end while (!out_valid && w < 50);
    out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk); #2; rst = 1'b1; #1;
    n_cmp += 5;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL rst_mid in_ready got %b want 1", in_ready); end
    if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_mid busy got %b want 0", busy); end
    if (overflow !== 1'b0)  begin n_bad++; $display("FAIL rst_mid overflow got %b want 0", overflow); end
    if (prob_flat !== '0)   begin n_bad++; $display("FAIL rst_mid prob got %h want 0", prob_flat); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (out_valid) seen++; end
    @(posedge clk); #1;
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL rst_mid stale beats got %0d want 0", seen); end
    gen_vec(2, 0);
    model(2);
    send(2, 1'b1);
    collect(0, 0);
    n_cmp += 3;
    if (ngot !== 2) begin n_bad++; $display("FAIL rst_mid next beats got %0d want 2", ngot); end
    if (gp[0] !== epk[0]) begin n_bad++; $display("FAIL rst_mid next prob0 got %h want %h", gp[0], epk[0]); end
    if (gp[1] !== epk[1]) begin n_bad++; $display("FAIL rst_mid next prob1 got %h want %h", gp[1], epk[1]); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_enable();
    test_overflow();
    test_rst_mid_out();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
